// File: rtl/spi_target_if.sv
// SPI pin bundle plus RX/TX FIFO strobes and status for spi_target.
// slave is the target's view; master is the initiator/FIFO side.
interface spi_target_if #(
  parameter int DATA = 8
);
  logic            scsn;
  logic            sclk;
  logic            mosi;
  logic            miso;
  logic            miso_oe;
  logic [DATA-1:0] wdata;
  logic            wr;
  logic            full;
  logic [DATA-1:0] rdata;
  logic            rd;
  logic            empty;
  logic            busy;
  logic [15:0]     bytecnt;
  logic            overrun;
  logic            underrun;
  logic            clr;

  modport slave (
    input  scsn, sclk, mosi, full, rdata, empty, clr,
    output miso, miso_oe, wdata, wr, rd, busy, bytecnt, overrun, underrun
  );

  modport master (
    output scsn, sclk, mosi, full, rdata, empty, clr,
    input  miso, miso_oe, wdata, wr, rd, busy, bytecnt, overrun, underrun
  );
endinterface

// File: rtl/spi_target.sv
// Mode-0 SPI target: oversamples scsn/sclk/mosi on clk, streams received words
// to an RX FIFO and transmits words popped from a TX FIFO, MSB first.
module spi_target #(
  parameter int              DATA  = 8,
  parameter logic [DATA-1:0] DUMMY = '0
) (
  input  logic        clk,
  input  logic        rst,
  spi_target_if.slave bus,
  output logic [1:0]  o_dbg_state
);

  localparam int BW = (DATA > 1) ? $clog2(DATA) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_cs_s, r_sck_s;
  logic [1:0]      r_mosi_s;
  logic [DATA-1:0] r_txreg, w_txreg_nxt;
  logic [DATA-1:0] r_rxreg, w_rxreg_nxt;
  logic [BW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic [DATA-1:0] r_wdata, w_wdata_nxt;
  logic            r_wr, w_wr_nxt;
  logic            w_rd;
  logic            r_busy, w_busy_nxt;
  logic [15:0]     r_bytecnt, w_bytecnt_nxt;
  logic            r_oe, w_oe_nxt;
  logic            r_miso;
  logic            r_overrun, r_underrun;
  logic            w_over_set, w_under_set;
  logic [DATA-1:0] w_word;
  logic            w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall, w_mosi;

  // Stage [1] is the synchronized value, stage [2] its one-cycle-old copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_s   <= 3'b111;
      r_sck_s  <= 3'b000;
      r_mosi_s <= 2'b00;
    end else begin
      r_cs_s   <= {r_cs_s[1:0], bus.scsn};
      r_sck_s  <= {r_sck_s[1:0], bus.sclk};
      r_mosi_s <= {r_mosi_s[0], bus.mosi};
    end
  end

  assign w_cs_fall  =  r_cs_s[2]  & ~r_cs_s[1];
  assign w_cs_rise  = ~r_cs_s[2]  &  r_cs_s[1];
  assign w_sck_rise = ~r_sck_s[2] &  r_sck_s[1];
  assign w_sck_fall =  r_sck_s[2] & ~r_sck_s[1];
  assign w_mosi     =  r_mosi_s[1];
  assign w_word     = {r_rxreg[DATA-2:0], w_mosi};

  // Handshake: wr and rd are single-cycle strobes with no back-pressure.
  // wr is only issued when full=0; rd pops the word presented on rdata in
  // the same cycle and is only issued when empty=0.
  always_comb begin
    w_state_nxt   = r_state;
    w_txreg_nxt   = r_txreg;
    w_rxreg_nxt   = r_rxreg;
    w_bitcnt_nxt  = r_bitcnt;
    w_wdata_nxt   = r_wdata;
    w_wr_nxt      = 1'b0;
    w_rd          = 1'b0;
    w_busy_nxt    = r_busy;
    w_bytecnt_nxt = r_bytecnt;
    w_oe_nxt      = r_oe;
    w_over_set    = 1'b0;
    w_under_set   = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt   = ST_LOAD;
            w_busy_nxt    = 1'b1;
            w_bytecnt_nxt = '0;
            w_bitcnt_nxt  = '0;
            w_rxreg_nxt   = '0;
            w_oe_nxt      = 1'b1;
          end
        end
        ST_LOAD: begin
          if (!bus.empty) begin
            w_txreg_nxt = bus.rdata;
            w_rd        = 1'b1;
          end else begin
            w_txreg_nxt = DUMMY;
            w_under_set = 1'b1;
          end
          w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_sck_rise) begin
            w_rxreg_nxt = w_word;
            if (r_bitcnt == BW'(DATA - 1)) begin
              w_bitcnt_nxt = '0;
              if (!bus.full) begin
                w_wdata_nxt = w_word;
                w_wr_nxt    = 1'b1;
              end else begin
                w_over_set = 1'b1;
              end
              if (r_bytecnt != 16'hFFFF) w_bytecnt_nxt = r_bytecnt + 16'd1;
            end else begin
              w_bitcnt_nxt = r_bitcnt + BW'(1);
            end
          end else if (w_sck_fall) begin
            if (r_bitcnt != '0) w_txreg_nxt = {r_txreg[DATA-2:0], 1'b0};
            else                w_state_nxt = ST_LOAD;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // miso follows the next txreg MSB so a freshly loaded word is on the pin
  // one clk after the LOAD cycle, well inside the minimum sclk low phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_txreg    <= '0;
      r_rxreg    <= '0;
      r_bitcnt   <= '0;
      r_wdata    <= '0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_bytecnt  <= '0;
      r_oe       <= 1'b0;
      r_miso     <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_txreg    <= w_txreg_nxt;
      r_rxreg    <= w_rxreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wr       <= w_wr_nxt;
      r_busy     <= w_busy_nxt;
      r_bytecnt  <= w_bytecnt_nxt;
      r_oe       <= w_oe_nxt;
      r_miso     <= w_oe_nxt & w_txreg_nxt[DATA-1];
      r_overrun  <= w_over_set  | (r_overrun  & ~bus.clr);
      r_underrun <= w_under_set | (r_underrun & ~bus.clr);
    end
  end

  assign bus.miso     = r_miso;
  assign bus.miso_oe  = r_oe;
  assign bus.wdata    = r_wdata;
  assign bus.wr       = r_wr;
  assign bus.rd       = w_rd;
  assign bus.busy     = r_busy;
  assign bus.bytecnt  = r_bytecnt;
  assign bus.overrun  = r_overrun;
  assign bus.underrun = r_underrun;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: an SPI initiator driver, a TX FIFO model,
// and a frame-level reference model predicting wr words, miso words and flags.
module tb_spi_target;

  localparam int              DATA    = 8;
  localparam logic [DATA-1:0] DUMMY_W = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] idle_code;

  spi_target_if #(.DATA(DATA)) bus ();

  spi_target #(.DATA(DATA), .DUMMY(DUMMY_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  int              n_rd     = 0;
  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] tx_q[$];
  logic [DATA-1:0] frame_words[$];
  logic [DATA-1:0] miso_got[$];
  logic            mdl_over, mdl_under;
  logic [15:0]     mdl_bytecnt;
  logic            busy_after4;
  logic            wr_prev = 1'b0, rd_prev = 1'b0, pop_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: wr scoreboard, strobe shape, TX FIFO pop and head presentation.
  always @(negedge clk) begin
    if (bus.wr) begin
      check_eq("wr_single", wr_prev, 0);
      check_eq("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("wdata", bus.wdata, exp_q.pop_front());
    end
    if (bus.rd) begin
      check_eq("rd_single", rd_prev, 0);
      check_eq("rd_busy", bus.busy, 1);
    end
    wr_prev = bus.wr;
    rd_prev = bus.rd;
    if (pop_pend && tx_q.size() != 0) begin
      void'(tx_q.pop_front());
      n_rd++;
    end
    pop_pend  = bus.rd && !rst;
    bus.rdata = (tx_q.size() != 0) ? tx_q[0] : '0;
    bus.empty = (tx_q.size() == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic spi_xfer(input int nbits);
    logic [DATA-1:0] w;
    logic [DATA-1:0] m;
    m = '0;
    miso_got.delete();
    @(negedge clk);
    bus.scsn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      w = frame_words[i / DATA];
      bus.mosi = w[DATA - 1 - (i % DATA)];
      repeat ($urandom_range(4, 7)) @(negedge clk);
      if (i == 0) begin
        check_eq("busy_active", bus.busy, 1);
        check_eq("oe_active", bus.miso_oe, 1);
      end
      m = {m[DATA-2:0], bus.miso};
      if (i % DATA == DATA - 1) miso_got.push_back(m);
      bus.sclk = 1'b1;
      repeat ($urandom_range(4, 7)) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    bus.scsn = 1'b1;
    repeat (4) @(negedge clk);
    busy_after4 = bus.busy;
    repeat (4) @(negedge clk);
  endtask

  // Frame-level model: word k of the frame carries TX FIFO entry k (or DUMMY
  // once the FIFO runs dry); one load happens at frame start and one after
  // every completed word, so loads = completed words + 1.
  task automatic do_frame(input int nbits, input logic full_v);
    logic [DATA-1:0] snap[$];
    int nwords, loads, rd0, exp_rd;
    snap   = tx_q;
    nwords = nbits / DATA;
    loads  = nwords + 1;
    exp_rd = (loads < snap.size()) ? loads : snap.size();
    rd0    = n_rd;
    bus.full = full_v;
    for (int i = 0; i < nwords; i++) if (!full_v) exp_q.push_back(frame_words[i]);
    if (full_v && nwords > 0) mdl_over = 1'b1;
    if (snap.size() < loads) mdl_under = 1'b1;
    mdl_bytecnt = 16'(nwords);
    spi_xfer(nbits);
    check_eq("miso_count", miso_got.size(), nwords);
    for (int i = 0; i < nwords && i < miso_got.size(); i++)
      check_eq($sformatf("miso_w%0d", i), miso_got[i], (i < snap.size()) ? snap[i] : DUMMY_W);
    check_eq("rd_count", n_rd - rd0, exp_rd);
    check_eq("wr_missing", exp_q.size(), 0);
    check_eq("busy_end", busy_after4, 0);
    check_eq("oe_end", bus.miso_oe, 0);
    check_eq("miso_end", bus.miso, 0);
    check_eq("bytecnt", bus.bytecnt, mdl_bytecnt);
    check_eq("overrun", bus.overrun, mdl_over);
    check_eq("underrun", bus.underrun, mdl_under);
    bus.full = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    @(negedge clk);
    mdl_over  = 1'b0;
    mdl_under = 1'b0;
    check_eq("clr_overrun", bus.overrun, mdl_over);
    check_eq("clr_underrun", bus.underrun, mdl_under);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_miso"}, bus.miso, 0);
    check_eq({tag, "_oe"}, bus.miso_oe, 0);
    check_eq({tag, "_wr"}, bus.wr, 0);
    check_eq({tag, "_rd"}, bus.rd, 0);
    check_eq({tag, "_wdata"}, bus.wdata, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_bytecnt"}, bus.bytecnt, 0);
    check_eq({tag, "_overrun"}, bus.overrun, 0);
    check_eq({tag, "_underrun"}, bus.underrun, 0);
  endtask

  task automatic fill_tx(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(DATA'($urandom));
  endtask

  task automatic fill_words(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back(DATA'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nw, nb;
    rst      = 1'b1;
    bus.scsn = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.full = 1'b0;
    bus.clr  = 1'b0;
    mdl_over = 1'b0;
    mdl_under = 1'b0;
    mdl_bytecnt = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    idle_code = dbg_state;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word frame against a two-entry TX FIFO.
    tx_q = '{8'hA5, 8'h3C};
    frame_words = '{8'h81, 8'h7E};
    do_frame(16, 1'b0);
    pulse_clr();

    // Empty TX FIFO: DUMMY goes out, underrun sets, no pops.
    tx_q.delete();
    frame_words = '{8'h55};
    do_frame(8, 1'b0);
    pulse_clr();

    // RX FIFO full for a whole three-word frame.
    fill_tx(3);
    fill_words(3);
    do_frame(24, 1'b1);
    pulse_clr();

    // Abort after five bits, then a clean frame must start at bit 0.
    fill_tx(2);
    fill_words(1);
    do_frame(5, 1'b0);
    fill_tx(3);
    fill_words(2);
    do_frame(16, 1'b0);
    pulse_clr();

    // Reset during bit 3 of a word.
    tx_q = '{8'h11};
    @(negedge clk);
    bus.scsn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
    end
    bus.mosi = 1'b1;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    bus.scsn = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_over = 1'b0;
    mdl_under = 1'b0;
    mdl_bytecnt = '0;
    repeat (6) @(negedge clk);
    fill_tx(2);
    frame_words = '{8'hC3};
    do_frame(8, 1'b0);

    // sclk activity while deselected must be ignored.
    begin
      int rd0;
      rd0 = n_rd;
      fill_tx(2);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bus.sclk = ~bus.sclk;
        bus.mosi = 1'($urandom);
        repeat (5) @(negedge clk);
      end
      check_eq("idle_rd", n_rd - rd0, 0);
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_bytecnt", bus.bytecnt, mdl_bytecnt);
      check_eq("idle_state", dbg_state, idle_code);
      check_eq("idle_wr_pending", exp_q.size(), 0);
    end

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      nw = $urandom_range(1, 4);
      nb = nw * DATA + (($urandom_range(0, 3) == 0) ? $urandom_range(1, DATA - 1) : 0);
      fill_tx($urandom_range(0, 5));
      fill_words(nw + 1);
      do_frame(nb, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) pulse_clr();
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
